decode_unit: RTL and testbench

- Decode stage directly downstream of instruction fetch/ROM.
- Consumes the RISC-V field bundle (RD, RS1, RS2, Funct7, Funct3, opcode) and classifies the RV32I instruction.
- Produces registered control signals plus pass-through register indices for the register file and ALU.
- Single-entry output register with valid/ready handshake; also keeps accepted and illegal instruction counters and a sticky end-of-program flag.

---
 rtl/decode_pkg.sv | 75 +++++++
 rtl/decode_ctrl.sv | 106 ++++++++++
 rtl/decode_unit.sv | 163 ++++++++++++++++
 tb/tb_decode_unit.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/decode_pkg.sv
// -----------------------------------------------------------------------------
// decode_pkg
// Shared definitions for the RV32I decode stage: opcode values, the ALU
// operation encoding, the bundled control word and a funct3->ALU-op helper.
// -----------------------------------------------------------------------------
package decode_pkg;

   // RV32I major opcodes
   localparam logic [6:0] OP_R      = 7'b0110011;
   localparam logic [6:0] OP_IMM    = 7'b0010011;
   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_JAL    = 7'b1101111;
   localparam logic [6:0] OP_JALR   = 7'b1100111;
   localparam logic [6:0] OP_LUI    = 7'b0110111;
   localparam logic [6:0] OP_AUIPC  = 7'b0010111;

   // The two legal funct7 values for register/shift operations
   localparam logic [6:0] F7_BASE = 7'b0000000;
   localparam logic [6:0] F7_ALT  = 7'b0100000;

   typedef enum logic [3:0] {
      ALU_ADD   = 4'd0,
      ALU_SUB   = 4'd1,
      ALU_SLL   = 4'd2,
      ALU_SLT   = 4'd3,
      ALU_SLTU  = 4'd4,
      ALU_XOR   = 4'd5,
      ALU_SRL   = 4'd6,
      ALU_SRA   = 4'd7,
      ALU_OR    = 4'd8,
      ALU_AND   = 4'd9,
      ALU_PASSB = 4'd10
   } alu_op_t;

   typedef struct packed {
      alu_op_t alu_op;
      logic    reg_write;
      logic    alu_src_imm;
      logic    mem_read;
      logic    mem_write;
      logic    branch;
      logic    jump;
   } ctrl_t;

   // Bubble / illegal control word: nothing happens, ALU idles on ADD
   localparam ctrl_t CTRL_NOP = '{
      alu_op:      ALU_ADD,
      reg_write:   1'b0,
      alu_src_imm: 1'b0,
      mem_read:    1'b0,
      mem_write:   1'b0,
      branch:      1'b0,
      jump:        1'b0
   };

   // funct3 -> ALU op for register and immediate arithmetic. alt selects
   // SUB (f3=000) or SRA (f3=101); callers only assert it where legal.
   function automatic alu_op_t alu_from_f3(input logic [2:0] f3, input logic alt);
      alu_op_t op;
      case (f3)
         3'b000:  op = alt ? ALU_SUB : ALU_ADD;
         3'b001:  op = ALU_SLL;
         3'b010:  op = ALU_SLT;
         3'b011:  op = ALU_SLTU;
         3'b100:  op = ALU_XOR;
         3'b101:  op = alt ? ALU_SRA : ALU_SRL;
         3'b110:  op = ALU_OR;
         default: op = ALU_AND;
      endcase
      return op;
   endfunction

endpackage

// File: rtl/decode_ctrl.sv
// -----------------------------------------------------------------------------
// decode_ctrl
// Purely combinational RV32I field decoder.
//   rd_i, rs1_i, rs2_i  : register index fields (rs1/rs2 only feed end detection)
//   funct7_i, funct3_i  : function fields
//   opcode_i            : major opcode
//   ctrl_o              : control word (all zero on illegal, reg_write masked for x0)
//   illegal_o           : unrecognised encoding
//   end_o               : all-zero bundle, the end-of-program marker
// -----------------------------------------------------------------------------
module decode_ctrl
   import decode_pkg::*;
(
   input  logic [4:0] rd_i,
   input  logic [4:0] rs1_i,
   input  logic [4:0] rs2_i,
   input  logic [6:0] funct7_i,
   input  logic [2:0] funct3_i,
   input  logic [6:0] opcode_i,
   output ctrl_t      ctrl_o,
   output logic       illegal_o,
   output logic       end_o
);

   ctrl_t ctrl;
   logic  ill;
   logic  alt;
   logic  f7_ok;

   assign alt   = (funct7_i == F7_ALT);
   assign f7_ok = (funct7_i == F7_BASE) || alt;
   assign end_o = ({rd_i, rs1_i, rs2_i, funct7_i, funct3_i, opcode_i} == '0);

   always_comb begin
      // NOTE: every signal written here gets a default first so no path
      // leaves it unassigned; otherwise synthesis infers a latch.
      ctrl = CTRL_NOP;
      ill  = 1'b0;

      case (opcode_i)
         OP_R: begin
            ctrl.reg_write = 1'b1;
            ctrl.alu_op    = alu_from_f3(funct3_i, alt);
            ill = !f7_ok || (alt && (funct3_i != 3'b000) && (funct3_i != 3'b101));
         end
         OP_IMM: begin
            ctrl.reg_write   = 1'b1;
            ctrl.alu_src_imm = 1'b1;
            // For the non-shift forms funct7 is immediate bits; only the
            // right shift may use it as the SRA selector (no SUBI).
            ctrl.alu_op      = alu_from_f3(funct3_i, alt && (funct3_i == 3'b101));
            ill = ((funct3_i == 3'b001) && (funct7_i != F7_BASE)) ||
                  ((funct3_i == 3'b101) && !f7_ok);
         end
         OP_LOAD: begin
            ctrl.reg_write   = 1'b1;
            ctrl.alu_src_imm = 1'b1;
            ctrl.mem_read    = 1'b1;
            ill = funct3_i inside {3'b011, 3'b110, 3'b111};
         end
         OP_STORE: begin
            ctrl.alu_src_imm = 1'b1;
            ctrl.mem_write   = 1'b1;
            ill = (funct3_i > 3'b010);
         end
         OP_BRANCH: begin
            ctrl.branch = 1'b1;
            ctrl.alu_op = ALU_SUB;
            ill = funct3_i inside {3'b010, 3'b011};
         end
         OP_JAL: begin
            ctrl.jump      = 1'b1;
            ctrl.reg_write = 1'b1;
         end
         OP_JALR: begin
            ctrl.jump        = 1'b1;
            ctrl.reg_write   = 1'b1;
            ctrl.alu_src_imm = 1'b1;
            ill = (funct3_i != 3'b000);
         end
         OP_LUI: begin
            ctrl.reg_write   = 1'b1;
            ctrl.alu_src_imm = 1'b1;
            ctrl.alu_op      = ALU_PASSB;
         end
         OP_AUIPC: begin
            ctrl.reg_write   = 1'b1;
            ctrl.alu_src_imm = 1'b1;
         end
         // The all-zero bundle is a legal bubble; any other unknown opcode is not.
         default: ill = !end_o;
      endcase

      if (ill) begin
         ctrl = CTRL_NOP;
      end
      // Writes to x0 are discarded at the source.
      if (rd_i == 5'd0) begin
         ctrl.reg_write = 1'b0;
      end
   end

   assign ctrl_o    = ctrl;
   assign illegal_o = ill;

endmodule

// File: rtl/decode_unit.sv
// -----------------------------------------------------------------------------
// decode_unit
// RV32I decode stage with a single-entry registered output and valid/ready
// handshake on both sides.
//   clk, rst                 : clock, asynchronous active-high reset
//   in_valid / in_ready      : upstream handshake for the field bundle
//   RD, RS1, RS2, Funct7, Funct3, opcode : instruction fields
//   out_valid / out_ready    : downstream handshake for the decoded entry
//   rd_o, rs1_o, rs2_o, funct3_o : registered pass-through fields
//   alu_op, reg_write, alu_src_imm, mem_read, mem_write, branch, jump,
//   illegal                  : registered decode
//   done                     : sticky, set by the all-zero end bundle
//   inst_count, ill_count    : saturating accepted / accepted-illegal counters
// -----------------------------------------------------------------------------
module decode_unit
   import decode_pkg::*;
#(
   parameter int CNT_W = 16,
   parameter int ILL_W = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [4:0]       RD,
   input  logic [4:0]       RS1,
   input  logic [4:0]       RS2,
   input  logic [6:0]       Funct7,
   input  logic [2:0]       Funct3,
   input  logic [6:0]       opcode,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [4:0]       rd_o,
   output logic [4:0]       rs1_o,
   output logic [4:0]       rs2_o,
   output logic [2:0]       funct3_o,
   output logic [3:0]       alu_op,
   output logic             reg_write,
   output logic             alu_src_imm,
   output logic             mem_read,
   output logic             mem_write,
   output logic             branch,
   output logic             jump,
   output logic             illegal,
   output logic             done,
   output logic [CNT_W-1:0] inst_count,
   output logic [ILL_W-1:0] ill_count
);

   localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
   localparam logic [ILL_W-1:0] ILL_ONE = {{(ILL_W-1){1'b0}}, 1'b1};

   ctrl_t dec_ctrl;
   logic  dec_illegal;
   logic  dec_end;
   logic  accept;

   logic             out_valid_q, out_valid_d;
   logic [4:0]       rd_q, rd_d, rs1_q, rs1_d, rs2_q, rs2_d;
   logic [2:0]       funct3_q, funct3_d;
   ctrl_t            ctrl_q, ctrl_d;
   logic             illegal_q, illegal_d;
   logic             done_q, done_d;
   logic [CNT_W-1:0] inst_cnt_q, inst_cnt_d;
   logic [ILL_W-1:0] ill_cnt_q, ill_cnt_d;

   decode_ctrl u_decode_ctrl (
      .rd_i      (RD),
      .rs1_i     (RS1),
      .rs2_i     (RS2),
      .funct7_i  (Funct7),
      .funct3_i  (Funct3),
      .opcode_i  (opcode),
      .ctrl_o    (dec_ctrl),
      .illegal_o (dec_illegal),
      .end_o     (dec_end)
   );

   // Ready whenever the slot is empty or being drained this cycle, so a
   // continuously ready consumer sees one entry per clock.
   assign in_ready = !done_q && (!out_valid_q || out_ready);
   assign accept   = in_valid && in_ready;

   always_comb begin
      out_valid_d = out_valid_q;
      rd_d        = rd_q;
      rs1_d       = rs1_q;
      rs2_d       = rs2_q;
      funct3_d    = funct3_q;
      ctrl_d      = ctrl_q;
      illegal_d   = illegal_q;
      done_d      = done_q;
      inst_cnt_d  = inst_cnt_q;
      ill_cnt_d   = ill_cnt_q;

      if (accept) begin
         out_valid_d = 1'b1;
         rd_d        = RD;
         rs1_d       = RS1;
         rs2_d       = RS2;
         funct3_d    = Funct3;
         ctrl_d      = dec_ctrl;
         illegal_d   = dec_illegal;
         if (dec_end) begin
            done_d = 1'b1;
         end
         if (inst_cnt_q != '1) begin
            inst_cnt_d = inst_cnt_q + CNT_ONE;
         end
         if (dec_illegal && (ill_cnt_q != '1)) begin
            ill_cnt_d = ill_cnt_q + ILL_ONE;
         end
      end else if (out_ready) begin
         out_valid_d = 1'b0;
      end
   end

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples its pre-edge inputs regardless of statement order.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         out_valid_q <= 1'b0;
         rd_q        <= '0;
         rs1_q       <= '0;
         rs2_q       <= '0;
         funct3_q    <= '0;
         ctrl_q      <= CTRL_NOP;
         illegal_q   <= 1'b0;
         done_q      <= 1'b0;
         inst_cnt_q  <= '0;
         ill_cnt_q   <= '0;
      end else begin
         out_valid_q <= out_valid_d;
         rd_q        <= rd_d;
         rs1_q       <= rs1_d;
         rs2_q       <= rs2_d;
         funct3_q    <= funct3_d;
         ctrl_q      <= ctrl_d;
         illegal_q   <= illegal_d;
         done_q      <= done_d;
         inst_cnt_q  <= inst_cnt_d;
         ill_cnt_q   <= ill_cnt_d;
      end
   end

   assign out_valid   = out_valid_q;
   assign rd_o        = rd_q;
   assign rs1_o       = rs1_q;
   assign rs2_o       = rs2_q;
   assign funct3_o    = funct3_q;
   assign alu_op      = ctrl_q.alu_op;
   assign reg_write   = ctrl_q.reg_write;
   assign alu_src_imm = ctrl_q.alu_src_imm;
   assign mem_read    = ctrl_q.mem_read;
   assign mem_write   = ctrl_q.mem_write;
   assign branch      = ctrl_q.branch;
   assign jump        = ctrl_q.jump;
   assign illegal     = illegal_q;
   assign done        = done_q;
   assign inst_count  = inst_cnt_q;
   assign ill_count   = ill_cnt_q;

endmodule

// File: tb/tb_decode_unit.sv
// -----------------------------------------------------------------------------
// tb_decode_unit
// Directed self-checking bench for decode_unit. Inputs change 1 ns after the
// rising edge and outputs are sampled at that same point, well away from it.
// Control word compared as {illegal, reg_write, alu_src_imm, mem_read,
// mem_write, branch, jump, alu_op[3:0]}.
// -----------------------------------------------------------------------------
module tb_decode_unit;

   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid;
   logic        in_ready;
   logic [4:0]  rd_in, rs1_in, rs2_in;
   logic [6:0]  f7_in;
   logic [2:0]  f3_in;
   logic [6:0]  op_in;
   logic        out_valid;
   logic        out_ready;
   logic [4:0]  rd_o, rs1_o, rs2_o;
   logic [2:0]  funct3_o;
   logic [3:0]  alu_op;
   logic        reg_write, alu_src_imm, mem_read, mem_write, branch, jump;
   logic        illegal, done;
   logic [15:0] inst_count;
   logic [7:0]  ill_count;

   int n_checks = 0;
   int n_fail   = 0;
   int exp_inst = 0;
   int exp_ill  = 0;

   logic [10:0] obs_ctrl;
   assign obs_ctrl = {illegal, reg_write, alu_src_imm, mem_read, mem_write,
                      branch, jump, alu_op};

   decode_unit #(.CNT_W(16), .ILL_W(8)) dut (
      .clk         (clk),
      .rst         (rst),
      .in_valid    (in_valid),
      .in_ready    (in_ready),
      .RD          (rd_in),
      .RS1         (rs1_in),
      .RS2         (rs2_in),
      .Funct7      (f7_in),
      .Funct3      (f3_in),
      .opcode      (op_in),
      .out_valid   (out_valid),
      .out_ready   (out_ready),
      .rd_o        (rd_o),
      .rs1_o       (rs1_o),
      .rs2_o       (rs2_o),
      .funct3_o    (funct3_o),
      .alu_op      (alu_op),
      .reg_write   (reg_write),
      .alu_src_imm (alu_src_imm),
      .mem_read    (mem_read),
      .mem_write   (mem_write),
      .branch      (branch),
      .jump        (jump),
      .illegal     (illegal),
      .done        (done),
      .inst_count  (inst_count),
      .ill_count   (ill_count)
   );

   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog expired");
   end

   task automatic drive(input logic [4:0] rd_v, input logic [4:0] rs1_v,
                        input logic [4:0] rs2_v, input logic [6:0] f7_v,
                        input logic [2:0] f3_v, input logic [6:0] op_v);
      rd_in  = rd_v;
      rs1_in = rs1_v;
      rs2_in = rs2_v;
      f7_in  = f7_v;
      f3_in  = f3_v;
      op_in  = op_v;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      tick();
      tick();
      n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
      n_checks++; if (obs_ctrl !== 11'd0) begin n_fail++; $display("FAIL reset_ctrl: got %b want 0", obs_ctrl); end
      n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b want 0", done); end
      n_checks++; if ({inst_count, ill_count} !== 24'd0) begin n_fail++; $display("FAIL reset_counts: got %0d/%0d want 0/0", inst_count, ill_count); end
      n_checks++; if ({rd_o, rs1_o, rs2_o, funct3_o} !== 18'd0) begin n_fail++; $display("FAIL reset_fields: got %h want 0", {rd_o, rs1_o, rs2_o, funct3_o}); end
      @(negedge clk);
      rst = 1'b0;
      #1;
      n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
   endtask

   task automatic test_add();
      drive(5'd3, 5'd1, 5'd2, 7'h00, 3'd0, 7'b0110011);
      in_valid  = 1'b1;
      out_ready = 1'b1;
      tick();
      in_valid = 1'b0;
      exp_inst++;
      n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL add_out_valid: got %b want 1", out_valid); end
      n_checks++; if (obs_ctrl !== 11'b0_1_0_0_0_0_0_0000) begin n_fail++; $display("FAIL add_ctrl: got %b want 01000000000", obs_ctrl); end
      n_checks++; if ({rd_o, rs1_o, rs2_o} !== {5'd3, 5'd1, 5'd2}) begin n_fail++; $display("FAIL add_regs: got %0d,%0d,%0d want 3,1,2", rd_o, rs1_o, rs2_o); end
      n_checks++; if (inst_count !== 16'd1) begin n_fail++; $display("FAIL add_inst_count: got %0d want 1", inst_count); end
   endtask

   typedef struct packed {
      logic [4:0]  rd;
      logic [6:0]  f7;
      logic [2:0]  f3;
      logic [6:0]  op;
      logic [10:0] exp;  // {ill, rw, imm, mr, mw, br, j, alu_op}
   } vec_t;

   // Streamed back to back with out_ready high: one accept per cycle.
   task automatic test_decode_table();
      vec_t tbl [22] = '{
         '{5'd4, 7'h20, 3'd0, 7'b0110011, 11'b0_1_0_0_0_0_0_0001},  // SUB
         '{5'd4, 7'h20, 3'd5, 7'b0110011, 11'b0_1_0_0_0_0_0_0111},  // SRA
         '{5'd4, 7'h20, 3'd1, 7'b0110011, 11'b1_0_0_0_0_0_0_0000},  // alt f7 with SLL: illegal
         '{5'd6, 7'h00, 3'd3, 7'b0110011, 11'b0_1_0_0_0_0_0_0100},  // SLTU
         '{5'd6, 7'h01, 3'd0, 7'b0110011, 11'b1_0_0_0_0_0_0_0000},  // bad funct7
         '{5'd7, 7'h55, 3'd6, 7'b0010011, 11'b0_1_1_0_0_0_0_1000},  // ORI, f7 is imm
         '{5'd7, 7'h20, 3'd5, 7'b0010011, 11'b0_1_1_0_0_0_0_0111},  // SRAI
         '{5'd7, 7'h20, 3'd1, 7'b0010011, 11'b1_0_0_0_0_0_0_0000},  // SLLI f7!=0
         '{5'd7, 7'h10, 3'd5, 7'b0010011, 11'b1_0_0_0_0_0_0_0000},  // SRLI bad f7
         '{5'd8, 7'h00, 3'd3, 7'b0000011, 11'b1_0_0_0_0_0_0_0000},  // LOAD f3=011
         '{5'd8, 7'h00, 3'd3, 7'b0100011, 11'b1_0_0_0_0_0_0_0000},  // STORE f3=011
         '{5'd8, 7'h00, 3'd0, 7'b1100011, 11'b0_0_0_0_0_1_0_0001},  // BEQ
         '{5'd8, 7'h00, 3'd2, 7'b1100011, 11'b1_0_0_0_0_0_0_0000},  // BRANCH f3=010
         '{5'd8, 7'h00, 3'd7, 7'b1100011, 11'b0_0_0_0_0_1_0_0001},  // BGEU
         '{5'd1, 7'h3f, 3'd3, 7'b1101111, 11'b0_1_0_0_0_0_1_0000},  // JAL
         '{5'd1, 7'h00, 3'd0, 7'b1100111, 11'b0_1_1_0_0_0_1_0000},  // JALR
         '{5'd1, 7'h00, 3'd1, 7'b1100111, 11'b1_0_0_0_0_0_0_0000},  // JALR f3!=0
         '{5'd9, 7'h12, 3'd4, 7'b0110111, 11'b0_1_1_0_0_0_0_1010},  // LUI
         '{5'd0, 7'h12, 3'd4, 7'b0010111, 11'b0_0_1_0_0_0_0_0000},  // AUIPC x0
         '{5'd2, 7'h00, 3'd0, 7'b1111111, 11'b1_0_0_0_0_0_0_0000},  // unknown opcode
         '{5'd1, 7'h00, 3'd0, 7'b0000000, 11'b1_0_0_0_0_0_0_0000},  // opcode 0, not bubble
         '{5'd0, 7'h00, 3'd2, 7'b0100011, 11'b0_0_1_0_1_0_0_0000}   // SW
      };
      out_ready = 1'b1;
      for (int i = 0; i < 22; i++) begin
         drive(tbl[i].rd, 5'd1, 5'd2, tbl[i].f7, tbl[i].f3, tbl[i].op);
         in_valid = 1'b1;
         tick();
         exp_inst++;
         if (tbl[i].exp[10]) exp_ill++;
         n_checks++; if (obs_ctrl !== tbl[i].exp) begin n_fail++; $display("FAIL table_ctrl[%0d]: got %b want %b", i, obs_ctrl, tbl[i].exp); end
         n_checks++; if (!out_valid || rd_o !== tbl[i].rd || funct3_o !== tbl[i].f3) begin n_fail++; $display("FAIL table_entry[%0d]: got v=%b rd=%0d f3=%0d want v=1 rd=%0d f3=%0d", i, out_valid, rd_o, funct3_o, tbl[i].rd, tbl[i].f3); end
      end
      in_valid = 1'b0;
      tick();
      n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL table_drain: got out_valid=%b want 0", out_valid); end
      n_checks++; if (inst_count !== 16'(exp_inst)) begin n_fail++; $display("FAIL table_inst_count: got %0d want %0d", inst_count, exp_inst); end
      n_checks++; if (ill_count !== 8'(exp_ill)) begin n_fail++; $display("FAIL table_ill_count: got %0d want %0d", ill_count, exp_ill); end
   endtask

   task automatic test_backpressure();
      drive(5'd5, 5'd1, 5'd0, 7'h00, 3'd2, 7'b0000011);  // LW x5
      in_valid  = 1'b1;
      out_ready = 1'b1;
      tick();
      exp_inst++;
      n_checks++; if (obs_ctrl !== 11'b0_1_1_1_0_0_0_0000) begin n_fail++; $display("FAIL bp_load_ctrl: got %b want 01110000000", obs_ctrl); end
      drive(5'd4, 5'd1, 5'd5, 7'h00, 3'd2, 7'b0100011);  // SW offered while stalled
      out_ready = 1'b0;
      #1;
      n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL bp_in_ready_low: got %b want 0", in_ready); end
      for (int c = 0; c < 3; c++) begin
         tick();
         n_checks++; if (!out_valid || obs_ctrl !== 11'b0_1_1_1_0_0_0_0000 || rd_o !== 5'd5) begin n_fail++; $display("FAIL bp_hold[%0d]: got v=%b ctrl=%b rd=%0d want v=1 ctrl=01110000000 rd=5", c, out_valid, obs_ctrl, rd_o); end
         n_checks++; if (inst_count !== 16'(exp_inst)) begin n_fail++; $display("FAIL bp_count_hold[%0d]: got %0d want %0d", c, inst_count, exp_inst); end
      end
      out_ready = 1'b1;
      #1;
      n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL bp_in_ready_release: got %b want 1", in_ready); end
      tick();
      in_valid = 1'b0;
      exp_inst++;
      n_checks++; if (!out_valid || obs_ctrl !== 11'b0_0_1_0_1_0_0_0000 || rd_o !== 5'd4) begin n_fail++; $display("FAIL bp_store: got v=%b ctrl=%b rd=%0d want v=1 ctrl=00101000000 rd=4", out_valid, obs_ctrl, rd_o); end
      n_checks++; if (inst_count !== 16'(exp_inst)) begin n_fail++; $display("FAIL bp_inst_count: got %0d want %0d", inst_count, exp_inst); end
   endtask

   task automatic test_rd_x0();
      drive(5'd0, 5'd0, 5'd0, 7'h00, 3'd0, 7'b0010011);  // ADDI x0,x0,0
      in_valid  = 1'b1;
      out_ready = 1'b1;
      tick();
      in_valid = 1'b0;
      exp_inst++;
      n_checks++; if (obs_ctrl !== 11'b0_0_1_0_0_0_0_0000) begin n_fail++; $display("FAIL rdx0_ctrl: got %b want 00100000000", obs_ctrl); end
   endtask

   task automatic test_end();
      drive(5'd0, 5'd0, 5'd0, 7'h00, 3'd0, 7'h00);
      in_valid  = 1'b1;
      out_ready = 1'b1;
      tick();
      exp_inst++;
      n_checks++; if (done !== 1'b1 || in_ready !== 1'b0) begin n_fail++; $display("FAIL end_done: got done=%b in_ready=%b want 1/0", done, in_ready); end
      n_checks++; if (!out_valid || obs_ctrl !== 11'd0) begin n_fail++; $display("FAIL end_bubble: got v=%b ctrl=%b want v=1 ctrl=0", out_valid, obs_ctrl); end
      n_checks++; if (inst_count !== 16'(exp_inst)) begin n_fail++; $display("FAIL end_inst_count: got %0d want %0d", inst_count, exp_inst); end
      // Keep offering work and hold the bubble in place for the reset test.
      out_ready = 1'b0;
      drive(5'd3, 5'd1, 5'd2, 7'h00, 3'd0, 7'b0110011);
      for (int c = 0; c < 3; c++) begin
         tick();
         n_checks++; if (inst_count !== 16'(exp_inst) || in_ready !== 1'b0 || done !== 1'b1) begin n_fail++; $display("FAIL end_blocked[%0d]: got cnt=%0d in_ready=%b done=%b want %0d/0/1", c, inst_count, in_ready, done, exp_inst); end
      end
   endtask

   task automatic test_async_reset();
      tick();
      #2;
      rst = 1'b1;
      #1;
      n_checks++; if (out_valid !== 1'b0 || done !== 1'b0) begin n_fail++; $display("FAIL arst_state: got v=%b done=%b want 0/0", out_valid, done); end
      n_checks++; if ({inst_count, ill_count} !== 24'd0 || obs_ctrl !== 11'd0 || rd_o !== 5'd0) begin n_fail++; $display("FAIL arst_outputs: got cnt=%0d ill=%0d ctrl=%b rd=%0d want 0", inst_count, ill_count, obs_ctrl, rd_o); end
      #1;
      rst = 1'b0;
      #1;
      n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL arst_in_ready: got %b want 1", in_ready); end
      tick();
      in_valid = 1'b0;
      n_checks++; if (!out_valid || inst_count !== 16'd1 || obs_ctrl !== 11'b0_1_0_0_0_0_0_0000) begin n_fail++; $display("FAIL arst_restart: got v=%b cnt=%0d ctrl=%b want 1/1/01000000000", out_valid, inst_count, obs_ctrl); end
   endtask

   task automatic test_ill_saturate();
      out_ready = 1'b1;
      drive(5'd2, 5'd0, 5'd0, 7'h00, 3'd0, 7'b1111111);
      in_valid = 1'b1;
      repeat (260) @(posedge clk);
      #1;
      in_valid = 1'b0;
      n_checks++; if (ill_count !== 8'hFF) begin n_fail++; $display("FAIL ill_saturate: got %0d want 255", ill_count); end
      n_checks++; if (inst_count !== 16'd261) begin n_fail++; $display("FAIL sat_inst_count: got %0d want 261", inst_count); end
   endtask

   initial begin
      rst       = 1'b1;
      in_valid  = 1'b0;
      out_ready = 1'b0;
      drive(5'd0, 5'd0, 5'd0, 7'h00, 3'd0, 7'h00);
      test_reset();
      test_add();
      test_decode_table();
      test_backpressure();
      test_rd_x0();
      test_end();
      test_async_reset();
      test_ill_saturate();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
